regdst_pipe: RTL and testbench

//   Parametrised write-back destination selector with an elastic valid/ready pipeline.

---
 rtl/regdst_pipe.sv | 102 ++++++++++
 tb/tb_regdst_pipe.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regdst_pipe.sv
// regdst_pipe: write-back destination select carried through an elastic valid/ready pipe,
// with a pending-write scoreboard; define REGDST_STATS_EN to add stall_cnt/link_cnt counters.
module regdst_pipe #(
    parameter int AW        = 5,
    parameter int NSRC      = 2,
    parameter int SEL_W     = 2,
    parameter int LINK_ADDR = 31,
    parameter int DEPTH     = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [NSRC*AW-1:0] in_addr,
    input  logic [SEL_W-1:0]  sel,
    input  logic              in_wen,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [AW-1:0]     out_addr,
    output logic              out_wen,
    input  logic [AW-1:0]     rs_addr,
    input  logic [AW-1:0]     rt_addr,
    output logic              rs_busy,
    output logic              rt_busy
`ifdef REGDST_STATS_EN
    ,
    output logic [15:0]       stall_cnt,
    output logic [15:0]       link_cnt
`endif
);
    logic [DEPTH-1:0] v, wen_q, load;
    logic [AW-1:0]    addr_q [DEPTH];
    logic [AW-1:0]    sel_addr;

    always_comb begin
        sel_addr = AW'(LINK_ADDR);
        for (int k = 0; k < NSRC; k++)
            if (int'(sel) == k) sel_addr = in_addr[k*AW +: AW];
    end

    // A stage may load if it or any stage downstream of it is empty, or the output drains.
    always_comb begin
        logic free;
        free = out_ready;
        load = '0;
        for (int i = DEPTH-1; i >= 0; i--) begin
            free    = free || !v[i];
            load[i] = free;
        end
    end

    assign in_ready  = rst_n && !flush && load[0];
    assign out_valid = v[DEPTH-1];
    assign out_addr  = addr_q[DEPTH-1];
    assign out_wen   = wen_q[DEPTH-1];

    always_comb begin
        rs_busy = 1'b0;
        rt_busy = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            rs_busy = rs_busy || (v[i] && wen_q[i] && addr_q[i] == rs_addr && rs_addr != '0);
            rt_busy = rt_busy || (v[i] && wen_q[i] && addr_q[i] == rt_addr && rt_addr != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v     <= '0;
            wen_q <= '0;
            for (int i = 0; i < DEPTH; i++) addr_q[i] <= '0;
        end else if (flush) begin
            v <= '0;
        end else begin
            if (load[0]) begin
                v[0]      <= in_valid;
                addr_q[0] <= sel_addr;
                wen_q[0]  <= in_wen && sel_addr != '0;
            end
            for (int i = 1; i < DEPTH; i++)
                if (load[i]) begin
                    v[i]      <= v[i-1];
                    addr_q[i] <= addr_q[i-1];
                    wen_q[i]  <= wen_q[i-1];
                end
        end
    end

`ifdef REGDST_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            link_cnt  <= '0;
        end else begin
            if (out_valid && !out_ready && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
            if (in_valid && in_ready && int'(sel) >= NSRC && link_cnt != 16'hFFFF)
                link_cnt <= link_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_regdst_pipe.sv
// tb_regdst_pipe: vector table, directed corner sequences and a randomized run against
// an entry-list reference model of regdst_pipe (default parameters).
module tb_regdst_pipe;
    localparam int AW = 5, NSRC = 2, DEPTH = 2;

    logic clk = 0, rst_n = 0, flush = 0, in_valid = 0, in_wen = 0, out_ready = 0;
    logic [NSRC*AW-1:0] in_addr = '0;
    logic [1:0]         sel = '0;
    logic [AW-1:0]      rs_addr = '0, rt_addr = '0;
    logic               in_ready, out_valid, out_wen, rs_busy, rt_busy;
    logic [AW-1:0]      out_addr;
`ifdef REGDST_STATS_EN
    logic [15:0]        stall_cnt, link_cnt;
`endif
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    regdst_pipe dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .sel(sel), .in_wen(in_wen), .out_valid(out_valid),
        .out_ready(out_ready), .out_addr(out_addr), .out_wen(out_wen),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_busy(rs_busy), .rt_busy(rt_busy)
`ifdef REGDST_STATS_EN
        , .stall_cnt(stall_cnt), .link_cnt(link_cnt)
`endif
    );

    typedef struct {
        logic [1:0] s;
        int         rd, rt;
        logic       w;
        int         exp_addr;
        logic       exp_wen;
    } vec_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic          wen;
        int            pos;
    } ent_t;
    ent_t q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic vld, input logic [1:0] s, input int rd, input int rt, input logic w);
        in_valid = vld;
        sel      = s;
        in_addr  = {AW'(rt), AW'(rd)};
        in_wen   = w;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: list of in-flight entries, each with its stage position; entries slide
    // forward until they meet the entry ahead or the output, the head leaves when taken.
    task automatic model_step;
        logic [AW-1:0] a;
        bit acc;
        int lim;
        if (!rst_n || flush) begin
            q.delete();
            return;
        end
        acc = in_valid && (out_ready || q.size() < DEPTH);
        a = (sel < NSRC) ? in_addr[sel*AW +: AW] : AW'(31);
        if (q.size() > 0 && q[0].pos == DEPTH-1 && out_ready) void'(q.pop_front());
        for (int i = 0; i < q.size(); i++) begin
            lim = (i == 0) ? DEPTH-1 : q[i-1].pos - 1;
            q[i].pos = (q[i].pos + 1 < lim) ? q[i].pos + 1 : lim;
        end
        if (acc) q.push_back('{a, in_wen && a != 0, 0});
    endtask

    initial begin
        vec_t vecs[7];
        vecs[0] = '{2'd0, 4, 9, 1'b1, 4, 1'b1};
        vecs[1] = '{2'd1, 4, 9, 1'b1, 9, 1'b1};
        vecs[2] = '{2'd2, 4, 9, 1'b1, 31, 1'b1};
        vecs[3] = '{2'd3, 4, 9, 1'b1, 31, 1'b1};
        vecs[4] = '{2'd0, 0, 9, 1'b1, 0, 1'b0};
        vecs[5] = '{2'd1, 4, 0, 1'b1, 0, 1'b0};
        vecs[6] = '{2'd1, 4, 9, 1'b0, 9, 1'b0};

        out_ready = 1;
        tick; tick;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_addr", out_addr, 0);
        chk("rst_out_wen", out_wen, 0);
        chk("rst_in_ready", in_ready, 0);
        rst_n = 1;
        #1 chk("post_rst_in_ready", in_ready, 1);

        for (int j = 0; j < 7 + DEPTH - 1; j++) begin
            if (j < 7) drive(1, vecs[j].s, vecs[j].rd, vecs[j].rt, vecs[j].w);
            else drive(0, 0, 0, 0, 0);
            #1 if (j < 7) chk("tbl_in_ready", in_ready, 1);
            tick;
            if (j - (DEPTH-1) >= 0) begin
                chk("tbl_out_valid", out_valid, 1);
                chk("tbl_out_addr", out_addr, vecs[j-(DEPTH-1)].exp_addr);
                chk("tbl_out_wen", out_wen, vecs[j-(DEPTH-1)].exp_wen);
            end
        end
        drive(0, 0, 0, 0, 0);
        tick;
        chk("tbl_drained", out_valid, 0);

        // zero-register entry never reports busy
        drive(1, 0, 0, 9, 1);
        rs_addr = 0;
        tick;
        drive(0, 0, 0, 0, 0);
        #1 chk("zero_rs_busy", rs_busy, 0);
        tick; tick;

        // backpressure hold
        out_ready = 0;
        rs_addr = 7;
        drive(1, 0, 7, 0, 1);
        #1 chk("bp_in_ready", in_ready, 1);
        tick;
        drive(0, 0, 0, 0, 0);
        #1 chk("bp_busy_s0", rs_busy, 1);
        chk("bp_not_yet", out_valid, 0);
        tick;
        for (int c = 0; c < 5; c++) begin
            chk("bp_out_valid", out_valid, 1);
            chk("bp_out_addr", out_addr, 7);
            chk("bp_rs_busy", rs_busy, 1);
            chk("bp_in_ready_gap", in_ready, 1);
            tick;
        end
        rt_addr = 12;
        drive(1, 1, 0, 12, 1);
        #1 chk("bp_second_acc", in_ready, 1);
        tick;
        drive(0, 0, 0, 0, 0);
        #1 chk("bp_full_in_ready", in_ready, 0);
        chk("bp_rt_busy", rt_busy, 1);
        chk("bp_hold_addr", out_addr, 7);

        // flush of a full pipe
        flush = 1;
        drive(1, 0, 3, 0, 1);
        #1 chk("fl_in_ready", in_ready, 0);
        tick;
        flush = 0;
        drive(0, 0, 0, 0, 0);
        #1 chk("fl_out_valid", out_valid, 0);
        chk("fl_rs_busy", rs_busy, 0);
        chk("fl_rt_busy", rt_busy, 0);
        out_ready = 1;
        drive(1, 0, 3, 0, 1);
        #1 chk("fl_resume_rdy", in_ready, 1);
        tick;
        drive(0, 0, 0, 0, 0);
        tick;
        chk("fl_resume_valid", out_valid, 1);
        chk("fl_resume_addr", out_addr, 3);
        tick;

        // reset mid-stream
        out_ready = 0;
        rs_addr = 6;
        drive(1, 0, 6, 0, 1);
        tick;
        drive(1, 0, 8, 0, 1);
        tick;
        drive(0, 0, 0, 0, 0);
        #1 chk("rs_pre_valid", out_valid, 1);
        rst_n = 0;
        #1 chk("rs_in_ready_low", in_ready, 0);
        tick;
        chk("rs_out_valid", out_valid, 0);
        chk("rs_out_addr", out_addr, 0);
        chk("rs_out_wen", out_wen, 0);
        chk("rs_rs_busy", rs_busy, 0);
        rst_n = 1;
        out_ready = 1;
        drive(1, 1, 0, 13, 1);
        #1 chk("rs_acc_rdy", in_ready, 1);
        tick;
        drive(0, 0, 0, 0, 0);
        #1 chk("rs_lat1", out_valid, 0);
        tick;
        chk("rs_lat2_valid", out_valid, 1);
        chk("rs_lat2_addr", out_addr, 13);

`ifdef REGDST_STATS_EN
        rst_n = 0;
        tick;
        rst_n = 1;
        for (int c = 0; c < 3; c++) begin
            drive(1, 2, 1, 1, 1);
            tick;
        end
        drive(0, 0, 0, 0, 0);
        tick; tick; tick;
        out_ready = 0;
        drive(1, 0, 5, 0, 1);
        tick;
        drive(0, 0, 0, 0, 0);
        tick;
        repeat (4) tick;
        chk("st_link_cnt", link_cnt, 3);
        chk("st_stall_cnt", stall_cnt, 4);
        repeat (65540) @(posedge clk);
        #1 chk("st_stall_sat", stall_cnt, 16'hFFFF);
        tick;
        chk("st_stall_nowrap", stall_cnt, 16'hFFFF);
        out_ready = 1;
        tick; tick;
`endif

        // randomized run against the reference model
        rst_n = 0;
        flush = 0;
        drive(0, 0, 0, 0, 0);
        tick;
        q.delete();
        for (int c = 0; c < 600; c++) begin
            bit exp_ov, exp_rs, exp_rt;
            rst_n     = ($urandom_range(0, 99) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                  $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3) != 0);
            rs_addr = AW'($urandom_range(0, 7));
            rt_addr = AW'($urandom_range(0, 7));
            #1;
            exp_ov = 0;
            if (q.size() > 0) exp_ov = (q[0].pos == DEPTH-1);
            exp_rs = 0;
            exp_rt = 0;
            foreach (q[i]) begin
                if (q[i].wen && q[i].addr == rs_addr && rs_addr != 0) exp_rs = 1;
                if (q[i].wen && q[i].addr == rt_addr && rt_addr != 0) exp_rt = 1;
            end
            chk("rnd_in_ready", in_ready, rst_n && !flush && (out_ready || q.size() < DEPTH));
            chk("rnd_out_valid", out_valid, exp_ov);
            chk("rnd_rs_busy", rs_busy, exp_rs);
            chk("rnd_rt_busy", rt_busy, exp_rt);
            if (exp_ov) begin
                chk("rnd_out_addr", out_addr, q[0].addr);
                chk("rnd_out_wen", out_wen, q[0].wen);
            end
            @(posedge clk);
            model_step();
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
